// File: rtl/pulse_meas.sv
// pulse_meas: fabric-side receiver for serialized pulse trains.
// Consumes one 8-bit deserialized word per clk_div cycle (bit 0 earliest)
// and measures each pulse's high width and the preceding low gap in bit
// times. It also counts pulses and ends a measurement on count or idle timeout.
//
// Ports:
//   clk_div, rst      - clock, synchronous active-high reset
//   data_i[7:0]       - sample word, bit 0 first in time
//   arm_i             - level; rising edge starts a measurement
//   pulse_num_i[10:0] - expected pulse count, 0 = run until timeout
//   timeout_us_i[15:0]- idle-low limit in us, 0 = disabled
//   width_o, gap_o    - last pulse width / preceding gap (bits)
//   meas_valid_o      - strobe when width_o/gap_o update
//   pulse_cnt_o       - pulses completed since arm
//   done_o            - strobe at end of measurement
//   timeout_o, err_o  - sticky status, cleared on arm
//   busy_o            - measurement in progress
//
// state    | meaning
// IDLE     | waiting for an arm edge
// WAIT_LOW | armed, line still high; waiting for a low bit
// LOW      | line low, accumulating gap and timeout
// HIGH     | line high, accumulating width
// DONE     | one-cycle end-of-measurement strobe
module pulse_meas #(
    parameter int WORDS_PER_US = 125,
    parameter int WIDTH_W      = 11,
    parameter int GAP_W        = 27
) (
    input  logic               clk_div,
    input  logic               rst,
    input  logic [7:0]         data_i,
    input  logic               arm_i,
    input  logic [10:0]        pulse_num_i,
    input  logic [15:0]        timeout_us_i,
    output logic [WIDTH_W-1:0] width_o,
    output logic [GAP_W-1:0]   gap_o,
    output logic               meas_valid_o,
    output logic [10:0]        pulse_cnt_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic               err_o,
    output logic               busy_o
);

    localparam int CYC_W = (WORDS_PER_US > 1) ? $clog2(WORDS_PER_US) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WORDS_PER_US - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_LOW, S_LOW, S_HIGH, S_DONE} state_t;

    // Index of the lowest set bit, 8 when the word is all zeros.
    function automatic logic [3:0] first_one(input logic [7:0] w);
        logic [3:0] idx;
        idx = 4'd8;
        for (int i = 7; i >= 0; i--)
            if (w[i]) idx = 4'(i);
        return idx;
    endfunction

    // Index of the lowest clear bit at or above lo, 8 when none.
    function automatic logic [3:0] first_zero_from(input logic [7:0] w, input logic [3:0] lo);
        logic [3:0] idx;
        idx = 4'd8;
        for (int i = 7; i >= 0; i--)
            if (!w[i] && (4'(i) >= lo)) idx = 4'(i);
        return idx;
    endfunction

    function automatic logic ones_above(input logic [7:0] w, input logic [3:0] f);
        logic any;
        any = 1'b0;
        for (int i = 0; i < 8; i++)
            if (w[i] && (4'(i) > f)) any = 1'b1;
        return any;
    endfunction

    function automatic logic [GAP_W-1:0] gap_add(input logic [GAP_W-1:0] g, input logic [3:0] n);
        logic [GAP_W:0] s;
        s = {1'b0, g} + (GAP_W+1)'(n);
        return s[GAP_W] ? '1 : s[GAP_W-1:0];
    endfunction

    // Input capture and arm edge detection.
    logic [7:0]  data_q;
    logic [10:0] pulse_num_q;
    logic [15:0] timeout_us_q;
    logic        arm_meta_q, arm_sync_q, arm_prev_q;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_acc_q, gap_acc_d;
    logic [WIDTH_W-1:0] width_acc_q, width_acc_d;
    logic               first_q, first_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [15:0]        us_q, us_d;
    logic [10:0]        cnt_q, cnt_d;
    logic [WIDTH_W-1:0] width_o_q, width_o_d;
    logic [GAP_W-1:0]   gap_o_q, gap_o_d;
    logic               meas_valid_q, meas_valid_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               err_q, err_d;

    logic               arm_edge, all_ones, publish, w_sat;
    logic [3:0]         r_idx, f_lo, f0, f_pub, w_inc;
    logic [WIDTH_W:0]   w_sum;
    logic [WIDTH_W-1:0] w_next, pub_width;
    logic [GAP_W-1:0]   pub_gap, gap_rise;

    always_ff @(posedge clk_div) begin
        if (rst) begin
            data_q       <= '0;
            pulse_num_q  <= '0;
            timeout_us_q <= '0;
            arm_meta_q   <= 1'b0;
            arm_sync_q   <= 1'b0;
            arm_prev_q   <= 1'b0;
            state_q      <= S_IDLE;
            gap_acc_q    <= '0;
            width_acc_q  <= '0;
            first_q      <= 1'b0;
            cyc_q        <= '0;
            us_q         <= '0;
            cnt_q        <= '0;
            width_o_q    <= '0;
            gap_o_q      <= '0;
            meas_valid_q <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            data_q       <= data_i;
            pulse_num_q  <= pulse_num_i;
            timeout_us_q <= timeout_us_i;
            arm_meta_q   <= arm_i;
            arm_sync_q   <= arm_meta_q;
            arm_prev_q   <= arm_sync_q;
            state_q      <= state_d;
            gap_acc_q    <= gap_acc_d;
            width_acc_q  <= width_acc_d;
            first_q      <= first_d;
            cyc_q        <= cyc_d;
            us_q         <= us_d;
            cnt_q        <= cnt_d;
            width_o_q    <= width_o_d;
            gap_o_q      <= gap_o_d;
            meas_valid_q <= meas_valid_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
        end
    end

    assign arm_edge = arm_sync_q & ~arm_prev_q;
    assign all_ones = &data_q;
    assign r_idx    = first_one(data_q);
    assign f_lo     = first_zero_from(data_q, r_idx + 4'd1);
    assign f0       = first_zero_from(data_q, 4'd0);
    assign w_inc    = all_ones ? 4'd8 : f0;
    assign w_sum    = {1'b0, width_acc_q} + (WIDTH_W+1)'(w_inc);
    assign w_sat    = w_sum[WIDTH_W];
    assign w_next   = w_sat ? '1 : w_sum[WIDTH_W-1:0];
    assign gap_rise = gap_add(gap_acc_q, r_idx);

    always_comb begin
        state_d      = state_q;
        gap_acc_d    = gap_acc_q;
        width_acc_d  = width_acc_q;
        first_d      = first_q;
        cyc_d        = cyc_q;
        us_d         = us_q;
        cnt_d        = cnt_q;
        width_o_d    = width_o_q;
        gap_o_d      = gap_o_q;
        meas_valid_d = 1'b0;
        done_d       = 1'b0;
        tmo_d        = tmo_q;
        err_d        = err_q;
        publish      = 1'b0;
        pub_width    = '0;
        pub_gap      = '0;
        f_pub        = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (arm_edge) begin
                    state_d     = S_WAIT_LOW;
                    cnt_d       = '0;
                    tmo_d       = 1'b0;
                    err_d       = 1'b0;
                    gap_acc_d   = '0;
                    width_acc_d = '0;
                    first_d     = 1'b1;
                    cyc_d       = '0;
                    us_d        = '0;
                end
            end
            S_WAIT_LOW: begin
                if (!all_ones) begin
                    state_d   = S_LOW;
                    gap_acc_d = '0;
                    cyc_d     = '0;
                    us_d      = '0;
                end
            end
            S_LOW: begin
                if (r_idx == 4'd8) begin
                    gap_acc_d = gap_add(gap_acc_q, 4'd8);
                    if (cyc_q == CYC_LAST) begin
                        cyc_d = '0;
                        if ((timeout_us_q != 16'd0) && (us_q == timeout_us_q - 16'd1)) begin
                            tmo_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            us_d = us_q + 16'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end
                end else begin
                    // A rise restarts the idle timer.
                    cyc_d = '0;
                    us_d  = '0;
                    if (f_lo != 4'd8) begin
                        publish   = 1'b1;
                        pub_width = WIDTH_W'(f_lo - r_idx);
                        pub_gap   = gap_rise;
                        f_pub     = f_lo;
                    end else begin
                        width_acc_d = WIDTH_W'(4'd8 - r_idx);
                        gap_acc_d   = gap_rise;
                        state_d     = S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                if (w_sat) err_d = 1'b1;
                if (all_ones) begin
                    width_acc_d = w_next;
                end else begin
                    publish   = 1'b1;
                    pub_width = w_next;
                    pub_gap   = gap_acc_q;
                    f_pub     = f0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (publish) begin
            width_o_d    = pub_width;
            gap_o_d      = first_q ? '0 : pub_gap;
            meas_valid_d = 1'b1;
            cnt_d        = cnt_q + 11'd1;
            first_d      = 1'b0;
            // Bits from the fall to the end of the word are already low.
            gap_acc_d    = GAP_W'(4'd8 - f_pub);
            if (ones_above(data_q, f_pub)) err_d = 1'b1;
            if ((pulse_num_q != 11'd0) && (cnt_q + 11'd1 == pulse_num_q))
                state_d = S_DONE;
            else
                state_d = S_LOW;
        end
    end

    assign width_o      = width_o_q;
    assign gap_o        = gap_o_q;
    assign meas_valid_o = meas_valid_q;
    assign pulse_cnt_o  = cnt_q;
    assign done_o       = done_q;
    assign timeout_o    = tmo_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pulse_meas.sv
module tb_pulse_meas;
    logic        clk_div = 1'b0;
    logic        rst;
    logic [7:0]  data_i;
    logic        arm_i;
    logic [10:0] pulse_num_i;
    logic [15:0] timeout_us_i;
    logic [10:0] width_o;
    logic [26:0] gap_o;
    logic        meas_valid_o;
    logic [10:0] pulse_cnt_o;
    logic        done_o, timeout_o, err_o, busy_o;

    pulse_meas #(.WORDS_PER_US(125), .WIDTH_W(11), .GAP_W(27)) dut (
        .clk_div(clk_div), .rst(rst), .data_i(data_i), .arm_i(arm_i),
        .pulse_num_i(pulse_num_i), .timeout_us_i(timeout_us_i),
        .width_o(width_o), .gap_o(gap_o), .meas_valid_o(meas_valid_o),
        .pulse_cnt_o(pulse_cnt_o), .done_o(done_o), .timeout_o(timeout_o),
        .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk_div = ~clk_div;

    int cyc = 0;
    always @(posedge clk_div) cyc <= cyc + 1;

    typedef struct {int cyc; int width; int gap; int cnt;} meas_t;
    typedef struct {int cyc; int cnt; int tmo; int err;} done_t;
    typedef struct {logic [7:0] w0, w1, w2, w3; int width; int err; int fall_idx;} vec_t;

    meas_t got_m[$], exp_m[$];
    done_t got_d[$], exp_d[$];
    meas_t mon_m;
    done_t mon_d;
    logic [7:0] ws[$];
    int stream_start;
    int n_vec = 0;
    int n_bad = 0;

    // Event monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk_div) begin
        if (meas_valid_o) begin
            mon_m.cyc = cyc; mon_m.width = int'(width_o);
            mon_m.gap = int'(gap_o); mon_m.cnt = int'(pulse_cnt_o);
            got_m.push_back(mon_m);
        end
        if (done_o) begin
            mon_d.cyc = cyc; mon_d.cnt = int'(pulse_cnt_o);
            mon_d.tmo = int'(timeout_o); mon_d.err = int'(err_o);
            got_d.push_back(mon_d);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    task automatic arm(input int pnum, input int tmo);
        arm_i = 1'b0;
        repeat (3) tick();
        pulse_num_i  = 11'(pnum);
        timeout_us_i = 16'(tmo);
        arm_i = 1'b1;
        repeat (6) tick();
    endtask

    // Word n of ws is presented during cycle stream_start + n.
    task automatic drive();
        stream_start = cyc;
        for (int i = 0; i < ws.size(); i++) begin
            data_i = ws[i];
            tick();
        end
        data_i = 8'h00;
        repeat (6) tick();
        arm_i = 1'b0;
    endtask

    // Reference: walks the bit stream, pairing each rise with the next fall.
    // A fall in word n is reported two cycles after word n was presented.
    task automatic model_bits(input int pnum);
        int prev, rise, lastfall, k, b;
        logic [7:0] w;
        meas_t m;
        done_t d;
        prev = 0; rise = 0; lastfall = 0; k = 0;
        for (int i = 0; i < ws.size() * 8; i++) begin
            w = ws[i / 8];
            b = int'(w[i % 8]);
            if (b == 1 && prev == 0) rise = i;
            if (b == 0 && prev == 1 && (pnum == 0 || k < pnum)) begin
                m.cyc = stream_start + i / 8 + 2;
                m.width = i - rise;
                m.gap = (k == 0) ? 0 : rise - lastfall;
                m.cnt = k + 1;
                exp_m.push_back(m);
                lastfall = i;
                k++;
            end
            prev = b;
        end
        if (pnum != 0 && k == pnum) begin
            d.cyc = exp_m[exp_m.size() - 1].cyc + 1;
            d.cnt = k; d.tmo = 0; d.err = 0;
            exp_d.push_back(d);
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, " meas_count"}, got_m.size(), exp_m.size());
        for (int i = 0; i < exp_m.size(); i++) begin
            if (i < got_m.size()) begin
                chk({tag, " meas_cycle"}, got_m[i].cyc - stream_start, exp_m[i].cyc - stream_start);
                chk({tag, " width"}, got_m[i].width, exp_m[i].width);
                chk({tag, " gap"}, got_m[i].gap, exp_m[i].gap);
                chk({tag, " cnt"}, got_m[i].cnt, exp_m[i].cnt);
            end
        end
        chk({tag, " done_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < got_d.size()) begin
                chk({tag, " done_cycle"}, got_d[i].cyc - stream_start, exp_d[i].cyc - stream_start);
                chk({tag, " done_cnt"}, got_d[i].cnt, exp_d[i].cnt);
                chk({tag, " timeout"}, got_d[i].tmo, exp_d[i].tmo);
                chk({tag, " err"}, got_d[i].err, exp_d[i].err);
            end
        end
        got_m.delete(); exp_m.delete(); got_d.delete(); exp_d.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " width_o"}, width_o, 0);
        chk({tag, " gap_o"}, gap_o, 0);
        chk({tag, " pulse_cnt_o"}, pulse_cnt_o, 0);
        chk({tag, " meas_valid_o"}, meas_valid_o, 0);
        chk({tag, " done_o"}, done_o, 0);
        chk({tag, " timeout_o"}, timeout_o, 0);
        chk({tag, " err_o"}, err_o, 0);
        chk({tag, " busy_o"}, busy_o, 0);
    endtask

    vec_t vecs[8];
    meas_t em;
    done_t ed;

    initial begin
        vecs[0] = '{8'h00, 8'hF0, 8'hFF, 8'h03, 14, 0, 3};
        vecs[1] = '{8'h1C, 8'h00, 8'h00, 8'h00, 3, 0, 0};
        vecs[2] = '{8'h55, 8'h00, 8'h00, 8'h00, 1, 1, 0};
        vecs[3] = '{8'h80, 8'hFF, 8'h01, 8'h00, 10, 0, 2};
        vecs[4] = '{8'h80, 8'h00, 8'h00, 8'h00, 1, 0, 1};
        vecs[5] = '{8'hF0, 8'hF0, 8'h00, 8'h00, 4, 1, 1};
        vecs[6] = '{8'h00, 8'h7F, 8'h00, 8'h00, 7, 0, 1};
        vecs[7] = '{8'hFE, 8'hFF, 8'hFF, 8'h00, 23, 0, 3};

        rst = 1'b1; data_i = 8'h00; arm_i = 1'b0;
        pulse_num_i = '0; timeout_us_i = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single-pulse table, each preceded by two low words.
        for (int v = 0; v < 8; v++) begin
            arm(1, 0);
            ws.delete();
            ws.push_back(8'h00); ws.push_back(8'h00);
            ws.push_back(vecs[v].w0); ws.push_back(vecs[v].w1);
            ws.push_back(vecs[v].w2); ws.push_back(vecs[v].w3);
            repeat (4) ws.push_back(8'h00);
            drive();
            em.cyc = stream_start + 2 + vecs[v].fall_idx + 2;
            em.width = vecs[v].width; em.gap = 0; em.cnt = 1;
            exp_m.push_back(em);
            ed.cyc = em.cyc + 1; ed.cnt = 1; ed.tmo = 0; ed.err = vecs[v].err;
            exp_d.push_back(ed);
            compare($sformatf("table%0d", v));
        end

        // Three width-5 pulses separated by 250 low words: gaps 0, 2003, 2003.
        arm(3, 0);
        ws.delete();
        repeat (2) ws.push_back(8'h00);
        for (int p = 0; p < 3; p++) begin
            ws.push_back(8'h1F);
            repeat (250) ws.push_back(8'h00);
        end
        drive();
        model_bits(3);
        chk("train gap2 value", exp_m[1].gap, 2003);
        compare("train");

        // Timeout 2 us: intra-word pulse at word 5, timeout on the 250th low word after it.
        arm(0, 2);
        ws.delete();
        repeat (5) ws.push_back(8'h00);
        ws.push_back(8'h1C);
        repeat (260) ws.push_back(8'h00);
        drive();
        em.cyc = stream_start + 5 + 2; em.width = 3; em.gap = 0; em.cnt = 1;
        exp_m.push_back(em);
        ed.cyc = stream_start + 5 + 250 + 3; ed.cnt = 1; ed.tmo = 1; ed.err = 0;
        exp_d.push_back(ed);
        compare("timeout");

        // Width saturation: 300 high words, then low.
        arm(1, 0);
        ws.delete();
        repeat (2) ws.push_back(8'h00);
        repeat (300) ws.push_back(8'hFF);
        repeat (5) ws.push_back(8'h00);
        drive();
        em.cyc = stream_start + 302 + 2; em.width = 2047; em.gap = 0; em.cnt = 1;
        exp_m.push_back(em);
        ed.cyc = em.cyc + 1; ed.cnt = 1; ed.tmo = 0; ed.err = 1;
        exp_d.push_back(ed);
        compare("saturate");

        // Random clean trains: each fall is followed by a rise no earlier than the next word.
        for (int round = 0; round < 5; round++) begin
            int np, pos, last_fall;
            int rs[8], fs[8];
            logic [7:0] w;
            np = $urandom_range(1, 6);
            pos = 24 + $urandom_range(0, 20);
            last_fall = 0;
            for (int p = 0; p < np; p++) begin
                rs[p] = pos;
                fs[p] = pos + $urandom_range(1, 40);
                last_fall = fs[p];
                pos = (fs[p] / 8 + 1) * 8 + $urandom_range(0, 30);
            end
            ws.delete();
            for (int i = 0; i < last_fall / 8 + 4; i++) ws.push_back(8'h00);
            for (int p = 0; p < np; p++)
                for (int j = rs[p]; j < fs[p]; j++) begin
                    w = ws[j / 8];
                    w[j % 8] = 1'b1;
                    ws[j / 8] = w;
                end
            arm(np, 0);
            drive();
            model_bits(np);
            compare($sformatf("random%0d", round));
        end

        // Arm while the line is high, then reset in the middle of a pulse.
        data_i = 8'hFF;
        arm(0, 0);
        chk("armhigh busy", busy_o, 1);
        chk("armhigh cnt", pulse_cnt_o, 0);
        chk("armhigh no_meas", got_m.size(), 0);
        data_i = 8'h00;
        repeat (3) tick();
        data_i = 8'hFF;
        repeat (4) tick();
        chk("midhigh busy", busy_o, 1);
        chk("midhigh no_meas", got_m.size(), 0);
        rst = 1'b1;
        arm_i = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst = 1'b0;
        data_i = 8'h00;
        repeat (4) tick();
        chk("postreset busy", busy_o, 0);
        chk("postreset events", got_m.size() + got_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
